window_3x3: RTL and testbench

WINDOW_3X3 -- requirements
Module: window_3x3

---
 rtl/window_3x3_pkg.sv | 20 ++
 rtl/window_3x3_line_buffer.sv | 27 ++
 rtl/window_3x3.sv | 139 +++++++++++++
 tb/tb_window_3x3.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_pkg.sv
// Shared pixel-stream constants and types for the 3x3 window and the gauss stage.
// Both stages must agree on pixel width and default frame geometry.
package window_3x3_pkg;

  localparam int unsigned PixW    = 8;
  localparam int unsigned DefImgW = 128;
  localparam int unsigned DefImgH = 128;
  localparam int unsigned WinTaps = 9;

  typedef logic [PixW-1:0] pix_t;

  // Tap k lives at [k]; tap 0 is top-left, tap 4 centre, tap 8 bottom-right.
  typedef logic [WinTaps-1:0][PixW-1:0] win_t;

  // Index width that stays legal for tiny depths.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_3x3_line_buffer.sv
// One image row of pixel storage: a single write port and an asynchronous read port.
// Contents are deliberately not reset; the window logic never exposes unwritten entries.
module line_buffer
  import window_3x3_pkg::*;
#(
  parameter int unsigned Depth = DefImgW,
  parameter int unsigned Width = PixW
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [idx_w(Depth)-1:0]   waddr_i,
  input  logic [Width-1:0]          wdata_i,
  input  logic [idx_w(Depth)-1:0]   raddr_i,
  output logic [Width-1:0]          rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/window_3x3.sv
// Raster-scan 3x3 window generator: two line buffers feed a 3x3 register array,
// producing one window per interior pixel with valid/ready flow control.
module window_3x3
  import window_3x3_pkg::*;
#(
  parameter int unsigned IMG_W = DefImgW,
  parameter int unsigned IMG_H = DefImgH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PixW-1:0] pix_i,
  input  logic            pix_valid_i,
  output logic            pix_ready_o,
  output logic [PixW-1:0] data_o_0,
  output logic [PixW-1:0] data_o_1,
  output logic [PixW-1:0] data_o_2,
  output logic [PixW-1:0] data_o_3,
  output logic [PixW-1:0] data_o_4,
  output logic [PixW-1:0] data_o_5,
  output logic [PixW-1:0] data_o_6,
  output logic [PixW-1:0] data_o_7,
  output logic [PixW-1:0] data_o_8,
  output logic            win_valid_o,
  input  logic            win_ready_i,
  output logic            frame_done_o
);

  localparam int unsigned ColW = idx_w(IMG_W);
  localparam int unsigned RowW = idx_w(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  win_t            win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  pix_t lb0_rd, lb1_rd;
  logic accept, col_last, row_last, win_qual;

  // Ready stays low during reset so nothing is accepted before the counters clear.
  assign pix_ready_o = !rst_i && (!win_valid_q || win_ready_i);
  assign accept      = pix_valid_i && pix_ready_o;
  assign col_last    = (col_q == ColLast);
  assign row_last    = (row_q == RowLast);
  assign win_qual    = (row_q >= RowW'(2)) && (col_q >= ColW'(2));

  // LB0 holds row-1, LB1 holds row-2; LB1 is refilled from LB0's pre-write value.
  line_buffer #(
    .Depth (IMG_W),
    .Width (PixW)
  ) u_lb0 (
    .clk_i   (clk_i),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (pix_i),
    .raddr_i (col_q),
    .rdata_o (lb0_rd)
  );

  line_buffer #(
    .Depth (IMG_W),
    .Width (PixW)
  ) u_lb1 (
    .clk_i   (clk_i),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (lb0_rd),
    .raddr_i (col_q),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = pix_i;
    end
  end

  // A qualifying accept replaces a consumed window in the same cycle, so no bubble.
  always_comb begin
    win_valid_d = win_valid_q;
    if (accept) begin
      win_valid_d = win_qual;
    end else if (win_ready_i) begin
      win_valid_d = 1'b0;
    end
    frame_done_d = accept && col_last && row_last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;
  assign data_o_0     = win_q[0];
  assign data_o_1     = win_q[1];
  assign data_o_2     = win_q[2];
  assign data_o_3     = win_q[3];
  assign data_o_4     = win_q[4];
  assign data_o_5     = win_q[5];
  assign data_o_6     = win_q[6];
  assign data_o_7     = win_q[7];
  assign data_o_8     = win_q[8];

endmodule

// File: tb/tb_window_3x3.sv
// Self-checking bench for window_3x3 on an 8x4 image, compared against a
// frame-image model that cuts windows directly out of a 2D pixel array.
module tb_window_3x3;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       pix_valid_i = 1'b0;
  logic       win_ready_i = 1'b0;
  logic [7:0] pix_i = '0;
  logic       pix_ready_o, win_valid_o, frame_done_o;
  logic [7:0] data_o_0, data_o_1, data_o_2, data_o_3, data_o_4;
  logic [7:0] data_o_5, data_o_6, data_o_7, data_o_8;
  logic [71:0] dut_win;

  int n_vec = 0;
  int n_err = 0;

  // Model state: current expected outputs plus the image seen so far this frame.
  int          mr = 0, mc = 0;
  logic        m_valid = 1'b0, m_fd = 1'b0;
  logic [71:0] m_win = '0;
  logic [7:0]  img [H][W];

  window_3x3 #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pix_i        (pix_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .data_o_0     (data_o_0),
    .data_o_1     (data_o_1),
    .data_o_2     (data_o_2),
    .data_o_3     (data_o_3),
    .data_o_4     (data_o_4),
    .data_o_5     (data_o_5),
    .data_o_6     (data_o_6),
    .data_o_7     (data_o_7),
    .data_o_8     (data_o_8),
    .win_valid_o  (win_valid_o),
    .win_ready_i  (win_ready_i),
    .frame_done_o (frame_done_o)
  );

  assign dut_win = {data_o_8, data_o_7, data_o_6, data_o_5, data_o_4,
                    data_o_3, data_o_2, data_o_1, data_o_0};

  always #5 clk = ~clk;

  // Window centred-below-right at (r,c) of an image whose pixel is r*W+c+off.
  function automatic logic [71:0] mk(input int r, input int c, input int off);
    logic [71:0] res;
    for (int k = 0; k < 9; k++) begin
      res[k*8 +: 8] = 8'((r - 2 + k / 3) * W + (c - 2 + k % 3) + off);
    end
    return res;
  endfunction

  // Drive one cycle of inputs and advance the model across the clock edge.
  task automatic tick(input logic v, input logic [7:0] p, input logic rdy, output logic acc);
    logic [71:0] nwin;
    logic        nvalid, nfd;
    pix_valid_i = v;
    pix_i       = p;
    win_ready_i = rdy;
    acc    = !rst_i && v && (!m_valid || rdy);
    nwin   = m_win;
    nvalid = m_valid;
    nfd    = 1'b0;
    if (rst_i) begin
      nvalid = 1'b0;
      nwin   = '0;
      mr     = 0;
      mc     = 0;
    end else if (acc) begin
      img[mr][mc] = p;
      nfd = (mr == H - 1) && (mc == W - 1);
      if (mr >= 2 && mc >= 2) begin
        for (int k = 0; k < 9; k++) nwin[k*8 +: 8] = img[mr - 2 + k / 3][mc - 2 + k % 3];
        nvalid = 1'b1;
      end else begin
        nvalid = 1'b0;
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end else if (rdy) begin
      nvalid = 1'b0;
    end
    @(posedge clk);
    m_win   = nwin;
    m_valid = nvalid;
    m_fd    = nfd;
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'($urandom), 8'($urandom), 1'($urandom), acc);
    n_vec++;
    if (win_valid_o !== 1'b0 || frame_done_o !== 1'b0 || pix_ready_o !== 1'b0 || dut_win !== '0)
    begin
      n_err++;
      $display("FAIL reset: valid=%b done=%b ready=%b win=%h, want 0 0 0 0",
               win_valid_o, frame_done_o, pix_ready_o, dut_win);
    end
    rst_i = 1'b0;
    #1;
    n_vec++;
    if (pix_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b, want 1", pix_ready_o);
    end
  endtask

  // Full frame streamed with no gaps and the consumer always ready.
  task automatic test_stream(input int off);
    logic acc;
    int   nwin_dut = 0, nfd = 0;
    for (int i = 0; i < W * H; i++) begin
      tick(1'b1, 8'(i + off), 1'b1, acc);
      n_vec++;
      if (!acc || win_valid_o !== m_valid || frame_done_o !== m_fd || pix_ready_o !== 1'b1 ||
          (m_valid && dut_win !== m_win)) begin
        n_err++;
        $display("FAIL stream px%0d: acc=%b valid=%b done=%b ready=%b win=%h, want 1 %b %b 1 %h",
                 i, acc, win_valid_o, frame_done_o, pix_ready_o, dut_win, m_valid, m_fd, m_win);
      end
      if (win_valid_o === 1'b1) nwin_dut++;
      if (frame_done_o === 1'b1) nfd++;
      if (i == 18 || i == 31) begin
        n_vec++;
        if (win_valid_o !== 1'b1 || dut_win !== mk(i / W, i % W, off)) begin
          n_err++;
          $display("FAIL stream_win_px%0d: valid=%b win=%h, want 1 %h",
                   i, win_valid_o, dut_win, mk(i / W, i % W, off));
        end
      end
    end
    tick(1'b0, 8'h00, 1'b1, acc);
    n_vec++;
    if (frame_done_o !== 1'b0 || win_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL stream_tail: done=%b valid=%b, want 0 0", frame_done_o, win_valid_o);
    end
    n_vec++;
    if (nwin_dut != (W - 2) * (H - 2) || nfd != 1) begin
      n_err++;
      $display("FAIL stream_counts: windows=%0d pulses=%0d, want %0d 1",
               nwin_dut, nfd, (W - 2) * (H - 2));
    end
  endtask

  // Random gaps and backpressure; explicit checks around the row-3 wrap.
  task automatic test_row_wrap();
    logic acc, v, rdy;
    int   i = 0, cyc = 0;
    while (i < W * H && cyc < 600) begin
      v   = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      tick(v, 8'(i), rdy, acc);
      cyc++;
      n_vec++;
      if (win_valid_o !== m_valid || frame_done_o !== m_fd || pix_ready_o !== (!m_valid || rdy) ||
          (m_valid && dut_win !== m_win)) begin
        n_err++;
        $display("FAIL wrap cyc%0d: valid=%b done=%b ready=%b win=%h, want %b %b %b %h",
                 cyc, win_valid_o, frame_done_o, pix_ready_o, dut_win, m_valid, m_fd,
                 !m_valid || rdy, m_win);
      end
      if (acc && (i == 24 || i == 25)) begin
        n_vec++;
        if (win_valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_nowin_px%0d: valid=%b, want 0", i, win_valid_o);
        end
      end
      if (acc && i == 26) begin
        n_vec++;
        if (win_valid_o !== 1'b1 || dut_win !== mk(3, 2, 0)) begin
          n_err++;
          $display("FAIL wrap_win_px26: valid=%b win=%h, want 1 %h", win_valid_o, dut_win,
                   mk(3, 2, 0));
        end
      end
      if (acc) i++;
    end
    if (i < W * H) begin
      n_vec++;
      n_err++;
      $display("FAIL wrap_timeout: accepted %0d of %0d", i, W * H);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    for (int i = 0; i < 21; i++) tick(1'b1, 8'(i), 1'b1, acc);
    for (int s = 0; s < 20; s++) begin
      tick(1'b1, 8'd21, 1'b0, acc);
      n_vec++;
      if (pix_ready_o !== 1'b0 || win_valid_o !== 1'b1 || dut_win !== mk(2, 4, 0) ||
          frame_done_o !== 1'b0) begin
        n_err++;
        $display("FAIL stall cyc%0d: ready=%b valid=%b win=%h, want 0 1 %h",
                 s, pix_ready_o, win_valid_o, dut_win, mk(2, 4, 0));
      end
    end
    for (int i = 21; i < W * H; i++) begin
      tick(1'b1, 8'(i), 1'b1, acc);
      n_vec++;
      if (!acc || win_valid_o !== m_valid || frame_done_o !== m_fd ||
          (m_valid && dut_win !== m_win) || (i == 21 && dut_win !== mk(2, 5, 0))) begin
        n_err++;
        $display("FAIL resume px%0d: acc=%b valid=%b done=%b win=%h, want 1 %b %b %h",
                 i, acc, win_valid_o, frame_done_o, dut_win, m_valid, m_fd, m_win);
      end
    end
  endtask

  // Two frames with no idle cycle between; frame 2 values are offset by 100.
  task automatic test_back_to_back();
    logic acc;
    int   nwin2 = 0;
    for (int i = 0; i < 2 * W * H; i++) begin
      tick(1'b1, 8'((i < W * H) ? i : i - W * H + 100), 1'b1, acc);
      n_vec++;
      if (!acc || win_valid_o !== m_valid || (m_valid && dut_win !== m_win) ||
          frame_done_o !== (i == W * H - 1 || i == 2 * W * H - 1)) begin
        n_err++;
        $display("FAIL b2b px%0d: acc=%b valid=%b done=%b win=%h, want 1 %b - %h",
                 i, acc, win_valid_o, frame_done_o, dut_win, m_valid, m_win);
      end
      if (i >= W * H && win_valid_o === 1'b1) begin
        nwin2++;
        n_vec++;
        for (int k = 0; k < 9; k++) begin
          if (dut_win[k*8 +: 8] < 8'd100) begin
            n_err++;
            $display("FAIL b2b_stale px%0d tap%0d: got %0d, want >=100", i, k, dut_win[k*8 +: 8]);
            break;
          end
        end
      end
    end
    n_vec++;
    if (nwin2 != (W - 2) * (H - 2)) begin
      n_err++;
      $display("FAIL b2b_count: got %0d windows, want %0d", nwin2, (W - 2) * (H - 2));
    end
  endtask

  task automatic test_random();
    logic acc, v, rdy;
    int   n = 0, cyc = 0;
    while (n < 2 * W * H && cyc < 1500) begin
      v   = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 3) != 0;
      tick(v, 8'($urandom), rdy, acc);
      cyc++;
      n_vec++;
      if (win_valid_o !== m_valid || frame_done_o !== m_fd || pix_ready_o !== (!m_valid || rdy) ||
          (m_valid && dut_win !== m_win)) begin
        n_err++;
        $display("FAIL random cyc%0d: valid=%b done=%b ready=%b win=%h, want %b %b %b %h",
                 cyc, win_valid_o, frame_done_o, pix_ready_o, dut_win, m_valid, m_fd,
                 !m_valid || rdy, m_win);
      end
      if (acc) n++;
    end
    if (n < 2 * W * H) begin
      n_vec++;
      n_err++;
      $display("FAIL random_timeout: accepted %0d of %0d", n, 2 * W * H);
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    for (int i = 0; i < 13; i++) tick(1'b1, 8'(i + 50), 1'b1, acc);
    rst_i = 1'b1;
    tick(1'b1, 8'd99, 1'b1, acc);
    n_vec++;
    if (pix_ready_o !== 1'b0 || win_valid_o !== 1'b0 || frame_done_o !== 1'b0 || dut_win !== '0)
    begin
      n_err++;
      $display("FAIL midreset: ready=%b valid=%b done=%b win=%h, want 0 0 0 0",
               pix_ready_o, win_valid_o, frame_done_o, dut_win);
    end
    rst_i = 1'b0;
    test_stream(0);
  endtask

  initial begin
    test_reset();
    test_stream(0);
    test_row_wrap();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
